// File: rtl/serializer_pkg.sv
// Shared types, constants and helpers for the packed byte serializer.
package serializer_pkg;

    localparam int DATA_BITS = 8;
    localparam logic TX_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Clock cycles from the falling edge of the start bit to the end of the stop bit.
    function automatic int frame_len(input int clks_per_bit, input int parity_en);
        return (10 + parity_en) * clks_per_bit;
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serializer_bit_timer.sv
// Bit-period timer: bit_end is high in the last clock cycle of every serial bit.
module serializer_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end
);

    localparam int W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_cnt;

    assign bit_end = (r_cnt == LAST);

    // Cycle counter, wraps at the end of each bit period and is held at zero by restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1'b1);
        end
    end

endmodule

// File: rtl/packed_byte_serializer.sv
// Accepts packed status bytes into a one-entry holding register and shifts them
// out as framed serial words: start, 8 data bits MSB first, optional even parity, stop.
module packed_byte_serializer
    import serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_hold;
    logic [7:0]  w_hold_next;
    logic        r_hold_full;
    logic        w_hold_full_next;
    logic [7:0]  r_sr;
    logic [7:0]  w_sr_next;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  w_bit_cnt_next;
    logic        r_par;
    logic        w_par_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        w_load;
    logic        w_bit_end;
    logic        w_restart;

    // The timer is parked at zero while idle so the start bit always gets a full period.
    assign w_restart = (r_state == IDLE);

    serializer_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(w_restart),
        .bit_end(w_bit_end)
    );

    assign in_ready   = !r_hold_full;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == STOP) && w_bit_end;

    // Next-state, holding register, shifter and line-level logic.
    always_comb begin
        w_state_next     = r_state;
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
        w_sr_next        = r_sr;
        w_bit_cnt_next   = r_bit_cnt;
        w_par_next       = r_par;
        w_tx_next        = r_tx;
        w_load           = 1'b0;

        if (in_valid && !r_hold_full) begin
            w_hold_next      = in_data;
            w_hold_full_next = 1'b1;
        end else begin
            w_hold_full_next = r_hold_full;
        end

        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load = 1'b1;
                end else begin
                    w_tx_next = TX_IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next   = DATA;
                    w_bit_cnt_next = 3'd0;
                    w_tx_next      = r_sr[7];
                end else begin
                    w_tx_next = START_LVL;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            w_state_next = PARITY;
                            w_tx_next    = r_par;
                        end else begin
                            w_state_next = STOP;
                            w_tx_next    = TX_IDLE;
                        end
                    end else begin
                        w_sr_next      = {r_sr[6:0], 1'b0};
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        w_tx_next      = r_sr[6];
                    end
                end else begin
                    w_tx_next = r_tx;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                    w_tx_next    = TX_IDLE;
                end else begin
                    w_tx_next = r_tx;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                        w_tx_next    = TX_IDLE;
                    end
                end else begin
                    w_tx_next = TX_IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = TX_IDLE;
            end
        endcase

        // Loading only happens while hold is full, so it never collides with an accept.
        if (w_load) begin
            w_state_next     = START;
            w_sr_next        = r_hold;
            w_par_next       = even_parity(r_hold);
            w_hold_full_next = 1'b0;
            w_tx_next        = START_LVL;
        end else begin
            w_sr_next = w_sr_next;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_sr        <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_par       <= 1'b0;
            r_tx        <= TX_IDLE;
        end else begin
            r_state     <= w_state_next;
            r_hold      <= w_hold_next;
            r_hold_full <= w_hold_full_next;
            r_sr        <= w_sr_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_par       <= w_par_next;
            r_tx        <= w_tx_next;
        end
    end

endmodule

// File: tb/tb_packed_byte_serializer.sv
// Directed bench for packed_byte_serializer: one 4-clock/parity instance and one 1-clock/no-parity instance.
module tb_packed_byte_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_a = 1'b0;
    logic [7:0] in_data_a = 8'h00;
    logic       in_ready_a, tx_a, busy_a, fd_a;
    logic       in_valid_b = 1'b0;
    logic [7:0] in_data_b = 8'h00;
    logic       in_ready_b, tx_b, busy_b, fd_b;

    int checks = 0;
    int errors = 0;

    // Frames as line levels, MSB first: start, data[7:0], parity, stop.
    localparam logic [10:0] F_D7 = 11'b0_11010111_0_1;
    localparam logic [10:0] F_00 = 11'b0_00000000_0_1;
    localparam logic [10:0] F_3C = 11'b0_00111100_0_1;
    localparam logic [10:0] F_01 = 11'b0_00000001_1_1;
    localparam logic [10:0] F_FF = 11'b0_11111111_0_1;
    localparam logic [9:0]  F_A5 = 10'b0_10100101_1;

    packed_byte_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
    );

    packed_byte_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks instance A through frame cycles first..43, starting on cycle 'first'.
    task automatic frame_a(input logic [10:0] f, input int first, input logic rdy, input string tag);
        logic exp_bit;
        for (int i = first; i < 44; i++) begin
            exp_bit = f[10 - i / 4];
            check({tag, "_tx"}, 32'(tx_a), 32'(exp_bit));
            check({tag, "_fd"}, 32'(fd_a), (i == 43) ? 32'd1 : 32'd0);
            check({tag, "_busy"}, 32'(busy_a), 32'd1);
            check({tag, "_rdy"}, 32'(in_ready_a), 32'(rdy));
            tick();
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic [10:0] f, input string tag);
        in_valid_a = 1'b1;
        in_data_a  = d;
        check({tag, "_rdy0"}, 32'(in_ready_a), 32'd1);
        tick();
        in_valid_a = 1'b0;
        in_data_a  = 8'h00;
        check({tag, "_tx_e0"}, 32'(tx_a), 32'd1);
        check({tag, "_rdy_e0"}, 32'(in_ready_a), 32'd0);
        check({tag, "_busy_e0"}, 32'(busy_a), 32'd0);
        tick();
        frame_a(f, 0, 1'b1, tag);
        check({tag, "_idle"}, {29'd0, tx_a, busy_a, fd_a}, {29'd0, 3'b100});
    endtask

    initial begin
        // 1: reset and quiet line
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t1_a", {28'd0, tx_a, busy_a, in_ready_a, fd_a}, {28'd0, 4'b1010});
            check("t1_b", {28'd0, tx_b, busy_b, in_ready_b, fd_b}, {28'd0, 4'b1010});
        end

        // 2: single 8'hD7 frame
        send_a(8'hD7, F_D7, "t2");

        // 3: back-to-back D7, 00, with a stalled third byte 3C
        in_valid_a = 1'b1;
        in_data_a  = 8'hD7;
        check("t3_rdy_a", 32'(in_ready_a), 32'd1);
        tick();
        in_data_a = 8'h00;
        check("t3_rdy_b", 32'(in_ready_a), 32'd0);
        tick();
        check("t3_tx_f1s", 32'(tx_a), 32'd0);
        check("t3_rdy_c", 32'(in_ready_a), 32'd1);
        tick();
        in_data_a = 8'h3C;
        frame_a(F_D7, 1, 1'b0, "t3_f1");
        check("t3_gap_tx", 32'(tx_a), 32'd0);
        check("t3_gap_busy", 32'(busy_a), 32'd1);
        check("t3_gap_rdy", 32'(in_ready_a), 32'd1);
        tick();
        in_valid_a = 1'b0;
        in_data_a  = 8'h00;
        frame_a(F_00, 1, 1'b0, "t3_f2");
        frame_a(F_3C, 0, 1'b1, "t3_f3");
        check("t3_idle", {29'd0, tx_a, busy_a, fd_a}, {29'd0, 3'b100});

        // 4: one clock per bit, no parity, 8'hA5
        in_valid_b = 1'b1;
        in_data_b  = 8'hA5;
        tick();
        in_valid_b = 1'b0;
        check("t4_tx_e0", 32'(tx_b), 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t4_tx", 32'(tx_b), 32'(F_A5[9 - i]));
            check("t4_fd", 32'(fd_b), (i == 9) ? 32'd1 : 32'd0);
            check("t4_busy", 32'(busy_b), 32'd1);
            tick();
        end
        check("t4_idle", {29'd0, tx_b, busy_b, fd_b}, {29'd0, 3'b100});

        // 5: parity values
        send_a(8'h01, F_01, "t5_01");
        send_a(8'hFF, F_FF, "t5_ff");

        // 6: reset during the third data bit with a byte waiting in hold
        in_valid_a = 1'b1;
        in_data_a  = 8'hD7;
        tick();
        in_data_a = 8'h5A;
        tick();
        tick();
        in_valid_a = 1'b0;
        repeat (12) tick();
        check("t6_pre_tx", 32'(tx_a), 32'd0);
        check("t6_pre_rdy", 32'(in_ready_a), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst", {28'd0, tx_a, busy_a, in_ready_a, fd_a}, {28'd0, 4'b1010});
        for (int i = 0; i < 60; i++) begin
            tick();
            check("t6_quiet", {28'd0, tx_a, busy_a, in_ready_a, fd_a}, {28'd0, 4'b1010});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/packed_byte_serializer.md
Name: packed_byte_serializer

Overview:
- Downstream consumer of the 8-bit packed status byte from the field packer.
- Accepts one byte per valid/ready handshake into a single-entry holding register.
- Shifts each byte out on a single wire as a framed bit stream: start bit, 8 data bits MSB first, optional even parity, stop bit.
- Sits between the packer and the board-level serial link.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 1.
PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
clk  input  1  single system clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream byte valid.
in_data  input  8  packed byte, OUT[7:0] of the packer.
in_ready  output  1  holding register empty; a transfer occurs when in_valid && in_ready at a rising edge.
tx  output  1  serial line, idle high, registered.
busy  output  1  high whenever the FSM is not IDLE.
frame_done  output  1  one-cycle pulse in the final cycle of a stop bit.

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high (rst).
- Reset values: tx=1, busy=0, frame_done=0, hold empty (so in_ready=1 after reset releases), FSM=IDLE, bit counter=0, cycle timer=0.
- Reset mid-frame: the frame aborts and any held byte is discarded. tx is 1 from the cycle after the reset edge. No frame_done is generated.
- in_ready = !hold_full. It is driven from registered state only and never combinationally from in_valid.
- in_data is captured at the accepting edge; upstream need not hold it afterwards.
- FSM states:
  - IDLE: if hold_full, load the shift register from hold, clear hold, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, sr[7] first, shift left each bit period. After bit 8, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = ^data (even parity, so total ones including the parity bit is even). Then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - In the last cycle, frame_done=1.
    - Then, if hold_full, load and go directly to START (no idle gap); else go to IDLE.
- Latency: handshake at edge E0 means hold becomes full, IDLE loads at edge E1, and tx is low from E1 onward. Start bit therefore appears 2 cycles after the handshake cycle.
- Frame length: (10 + PARITY_EN) * CLKS_PER_BIT cycles from tx falling edge to end of the stop bit.
- Buffering:
  - A second byte may be accepted while a frame is in flight.
  - A third byte is stalled (in_ready=0) until the hold register is loaded into the shifter.
  - in_ready rises on the cycle after that load.
- Load and accept never coincide, because in_ready=0 while hold is full. No bypass path exists.
- CLKS_PER_BIT=1: every state lasts exactly one cycle, and the timer stays at 0.
- tx is registered. busy tracks the FSM state, including the START cycle entered from STOP.

Decomposition:
- Package serializer_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - DATA_BITS=8;
  - TX_IDLE=1'b1 and START_LVL=1'b0;
  - a function computing frame length from the parameters.
- Sub-module serializer_bit_timer: parameterised by CLKS_PER_BIT, width $clog2(CLKS_PER_BIT)+1.
  - Inputs: clk, rst, restart.
  - Output: bit_end, high in the last cycle of each bit period.
- The FSM, hold register, shift register and parity live in the top module.

Test Plan:
1. Reset release, no traffic -> tx=1, busy=0, in_ready=1, frame_done=0 for 20 cycles.
2. CLKS_PER_BIT=4, PARITY_EN=1, send 8'hD7 -> tx: 4 cycles at 0; bits 1,1,0,1,0,1,1,1 each 4 cycles; parity 0; stop 1. Frame is 44 cycles; frame_done asserts once in cycle 44; tx falls 2 cycles after the handshake.
3. Back-to-back 8'hD7 then 8'h00 with in_valid held high -> second byte accepted 1 cycle after the first. A third byte is stalled until the second loads. The second frame's start bit follows the first stop bit with no idle cycle; parity of 8'h00 is 0.
4. PARITY_EN=0, CLKS_PER_BIT=1, send 8'hA5 -> 10-cycle frame 0,1,0,1,0,0,1,0,1,1 with no parity slot.
5. PARITY_EN=1, send 8'h01 -> parity bit 1. Send 8'hFF -> parity bit 0.
6. Assert rst during DATA bit 3 with a second byte held -> tx=1 the next cycle, busy=0, in_ready=1. No frame_done and no later transmission of the held byte.
